// File: rtl/config_chain_loader_pkg.sv
// Shared definitions for the configuration chain loader.
// Package cfg_loader_pkg:
//   DEF_WORD_W / DEF_LEN_W : default bitstream word width and chain-length width
//   state_t                : loader FSM states (IDLE, FETCH, SHIFT, DONE)
//   cnt_width()            : width of a counter that must hold the value 0..w
package cfg_loader_pkg;

  localparam int DEF_WORD_W = 32;
  localparam int DEF_LEN_W  = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/config_chain_loader_if.sv
// Bitstream word stream into the configuration chain loader.
// Signals:
//   word_data  : bitstream word, MSB is shifted into the chain first
//   word_valid : word_data holds a word
//   word_ready : loader takes the word this cycle
// Handshake: a word transfers on a rising edge where word_valid and
// word_ready are both high; the source keeps word_data/word_valid stable
// until that edge, and word_ready never depends on word_valid.
// Modports: master = word source, slave = loader.
interface config_chain_loader_if
  import cfg_loader_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) ();

  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_data, output word_valid, input word_ready);
  modport slave  (input word_data, input word_valid, output word_ready);

endinterface

// File: rtl/config_chain_loader_packer.sv
// Readback packer: gathers chain-tail bits into words, first bit in the MSB.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   capture    : take bit_in this cycle (one chain shift)
//   bit_in     : serial bit from the chain tail
//   flush      : this capture is the last of the load; emit a partial word
//   rb_data    : packed readback word (partial words are zero-padded in the LSBs)
//   rb_valid   : one-cycle strobe for rb_data
module cfg_readback_packer
  import cfg_loader_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture,
  input  logic              bit_in,
  input  logic              flush,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);

  localparam int CW = cnt_width(WORD_W);
  localparam logic [CW-1:0] FULL = CW'(WORD_W);

  logic [WORD_W-1:0] pack;
  logic [CW-1:0]     cnt;
  logic [WORD_W-1:0] pack_next;
  logic [CW-1:0]     cnt_next;
  logic [CW-1:0]     pad;

  assign pack_next = {pack[WORD_W-2:0], bit_in};
  assign cnt_next  = cnt + CW'(1);
  // Left-justify a partial word so its first bit lands in the MSB.
  assign pad       = FULL - cnt_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      pack     <= '0;
      cnt      <= '0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (capture) begin
        if (cnt_next == FULL) begin
          rb_data  <= pack_next;
          rb_valid <= 1'b1;
          pack     <= '0;
          cnt      <= '0;
        end else if (flush) begin
          rb_data  <= pack_next << pad;
          rb_valid <= 1'b1;
          pack     <= '0;
          cnt      <= '0;
        end else begin
          pack <= pack_next;
          cnt  <= cnt_next;
        end
      end
    end
  end

endmodule

// File: rtl/config_chain_loader.sv
// Configuration chain loader: fetches bitstream words and shifts chain_len
// bits, MSB first, into a serial configuration chain.
// Optional feature: define CFG_READBACK_EN to pack the chain tail into
// readback words (rb_data/rb_valid); otherwise those outputs are tied to 0.
// Ports:
//   prog_clk, reset : clock and synchronous active-high reset
//   start, chain_len: load request and number of chain bits (latched in IDLE)
//   word_bus        : word stream (slave side)
//   sc_head, shift_en, config_enable, sc_tail : chain-side signals
//   busy, done      : busy outside IDLE; one-cycle completion pulse
//   rb_data, rb_valid : readback word and strobe
//   fsm_state       : current FSM state, for observation
module config_chain_loader
  import cfg_loader_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic                   prog_clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [LEN_W-1:0]       chain_len,
  config_chain_loader_if.slave   word_bus,
  output logic                   sc_head,
  output logic                   shift_en,
  output logic                   config_enable,
  input  logic                   sc_tail,
  output logic                   busy,
  output logic                   done,
  output logic [WORD_W-1:0]      rb_data,
  output logic                   rb_valid,
  output state_t                 fsm_state
);

  localparam int CW = cnt_width(WORD_W);

  state_t            state, state_next;
  logic [LEN_W-1:0]  remaining;
  logic [CW-1:0]     word_cnt;
  logic [WORD_W-1:0] shreg;
  logic              fetch_ready;
  logic              last_bit;

  assign word_bus.word_ready = fetch_ready;
  assign fsm_state           = state;
  assign last_bit            = (remaining == LEN_W'(1));

  always_ff @(posedge prog_clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      word_cnt  <= '0;
      shreg     <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (start) remaining <= chain_len;
        FETCH: if (word_bus.word_valid) begin
          shreg <= word_bus.word_data;
          // The last word may be only partly used; its spare LSBs are never shifted out.
          word_cnt <= (remaining < LEN_W'(WORD_W)) ? CW'(remaining) : CW'(WORD_W);
        end
        SHIFT: begin
          shreg     <= {shreg[WORD_W-2:0], 1'b0};
          word_cnt  <= word_cnt - CW'(1);
          remaining <= remaining - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next    = state;
    fetch_ready   = 1'b0;
    shift_en      = 1'b0;
    sc_head       = 1'b0;
    config_enable = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_next = (chain_len == '0) ? DONE : FETCH;
      end
      FETCH: begin
        fetch_ready   = 1'b1;
        config_enable = 1'b1;
        if (word_bus.word_valid) state_next = SHIFT;
      end
      SHIFT: begin
        shift_en      = 1'b1;
        sc_head       = shreg[WORD_W-1];
        config_enable = 1'b1;
        if (last_bit) state_next = DONE;
        else if (word_cnt == CW'(1)) state_next = FETCH;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

`ifdef CFG_READBACK_EN
  cfg_readback_packer #(.WORD_W(WORD_W)) u_packer (
    .clk      (prog_clk),
    .reset    (reset),
    .capture  (shift_en),
    .bit_in   (sc_tail),
    .flush    (shift_en && last_bit),
    .rb_data  (rb_data),
    .rb_valid (rb_valid)
  );
`else
  assign rb_data  = '0;
  assign rb_valid = 1'b0;
  logic unused_tail;
  assign unused_tail = sc_tail;
`endif

endmodule

// File: tb/tb_config_chain_loader.sv
// Directed bench for config_chain_loader. The chain is modelled as a 4-bit
// shift register clocked by shift_en, so sc_tail is sc_head delayed by four
// shifts. Readback expectations apply when CFG_READBACK_EN is defined.
module tb_config_chain_loader;
  import cfg_loader_pkg::*;

  localparam int WORD_W = 32;
  localparam int LEN_W  = 20;

  logic              prog_clk = 1'b0;
  logic              reset, start;
  logic [LEN_W-1:0]  chain_len;
  logic              sc_head, shift_en, config_enable, sc_tail, busy, done, rb_valid;
  logic [WORD_W-1:0] rb_data;
  state_t            fsm_state;

  config_chain_loader_if #(.WORD_W(WORD_W)) bus ();

  config_chain_loader #(.WORD_W(WORD_W), .LEN_W(LEN_W)) dut (
    .prog_clk      (prog_clk),
    .reset         (reset),
    .start         (start),
    .chain_len     (chain_len),
    .word_bus      (bus.slave),
    .sc_head       (sc_head),
    .shift_en      (shift_en),
    .config_enable (config_enable),
    .sc_tail       (sc_tail),
    .busy          (busy),
    .done          (done),
    .rb_data       (rb_data),
    .rb_valid      (rb_valid),
    .fsm_state     (fsm_state)
  );

  // clock / reset
  always #5 prog_clk = ~prog_clk;

  logic [3:0] chain;
  assign sc_tail = chain[3];
  always @(posedge prog_clk) begin
    if (reset) chain <= '0;
    else if (shift_en) chain <= {chain[2:0], sc_head};
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [0:0]        exp_q[$];
  logic [WORD_W-1:0] rb_q[$];
  logic [WORD_W-1:0] words[4];

  int nbits, first_shift, last_shift, done_cyc, bubbles, cfg_low, stall_bad;
  int done_after_abort;
  logic done_busy, done_cfg;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  // driver: one load; stall = cycles word_valid is withheld in FETCH,
  // poke = cycle index of an extra start pulse, abort_at = shift count at which reset hits
  task automatic load(input int len, input int nw, input int stall, input int poke, input int abort_at);
    int idx = 0;
    int cyc = 0;
    int stall_left = stall;
    bit accept, prev_stall, aborted;
    prev_stall = 0;
    aborted = 0;
    exp_q.delete();
    rb_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(words[i / WORD_W][WORD_W - 1 - (i % WORD_W)]);
    nbits = 0; first_shift = -1; last_shift = -1; done_cyc = -1;
    bubbles = 0; cfg_low = 0; stall_bad = 0; done_after_abort = 0;
    done_busy = 0; done_cfg = 0;
    chain_len = LEN_W'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc < 300) begin
      if (prev_stall && (fsm_state != FETCH || shift_en)) stall_bad++;
      if (shift_en) begin
        if (first_shift < 0) first_shift = cyc;
        else if (cyc != last_shift + 1) bubbles += cyc - last_shift - 1;
        last_shift = cyc;
        nbits++;
        if (exp_q.size() == 0) check("extra_bit", 1, 0);
        else check("bit", sc_head, exp_q.pop_front());
      end
      if (rb_valid) rb_q.push_back(rb_data);
      if (done) begin
        done_cyc = cyc; done_busy = busy; done_cfg = config_enable;
        break;
      end
      if (!config_enable) cfg_low++;
      if (abort_at > 0 && shift_en && nbits == abort_at) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_outs", {bus.word_ready, sc_head, shift_en, config_enable, busy, done, rb_valid}, 0);
        check("abort_rb_data", rb_data, 0);
        check("abort_state", fsm_state, IDLE);
        for (int k = 0; k < 6; k++) begin
          if (done) done_after_abort++;
          tick();
        end
        exp_q.delete();
        aborted = 1;
        break;
      end
      start = (cyc == poke);
      if (cyc == poke) chain_len = LEN_W'(3);
      prev_stall = 0;
      if (bus.word_ready && stall_left > 0) begin
        bus.word_valid = 1'b0;
        stall_left--;
        prev_stall = 1;
      end else begin
        bus.word_valid = (idx < nw);
        bus.word_data  = words[idx % 4];
      end
      accept = bus.word_ready && bus.word_valid;
      tick();
      cyc++;
      if (accept) idx++;
    end
    start = 1'b0;
    bus.word_valid = 1'b0;
    if (!aborted) begin
      if (done_cyc < 0) check("timeout_done", 0, 1);
      check("bits_left", exp_q.size(), 0);
      tick();
      check("done_one_cycle", done, 0);
      check("idle_after", {fsm_state, busy}, {IDLE, 1'b0});
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; chain_len = '0;
    bus.word_valid = 1'b0; bus.word_data = '0;
    repeat (3) tick();
    check("reset_outs", {bus.word_ready, sc_head, shift_en, config_enable, busy, done, rb_valid}, 0);
    check("reset_rb_data", rb_data, 0);
    check("reset_state", fsm_state, IDLE);
    reset = 1'b0;
    tick();

    // 8 bits of 0xA5000000: 1,0,1,0,0,1,0,1
    words[0] = 32'hA500_0000;
    load(8, 1, 0, -1, 0);
    check("t8_nbits", nbits, 8);
    check("t8_first", first_shift, 1);
    check("t8_bubbles", bubbles, 0);
    check("t8_cfg_low", cfg_low, 0);
    check("t8_done_cyc", done_cyc, 9);

    // 40 bits over two words: one bubble between them
    words[0] = 32'hFFFF_FFFF; words[1] = 32'h8000_0000;
    load(40, 2, 0, -1, 0);
    check("t40_nbits", nbits, 40);
    check("t40_bubbles", bubbles, 1);
    check("t40_last", last_shift, 41);
    check("t40_done_cyc", done_cyc, 42);
    check("t40_cfg_low", cfg_low, 0);

    // zero length: straight to DONE
    load(0, 0, 0, -1, 0);
    check("t0_done_cyc", done_cyc, 0);
    check("t0_nbits", nbits, 0);
    check("t0_done_flags", {done_busy, done_cfg}, 2'b10);

    // word withheld 5 cycles, extra start while busy
    words[0] = 32'h3C5A_F00F;
    load(12, 1, 5, 2, 0);
    check("stall_held", stall_bad, 0);
    check("stall_first", first_shift, 6);
    check("stall_nbits", nbits, 12);
    check("stall_done_cyc", done_cyc, 18);
    repeat (3) tick();
    check("stall_no_restart", {busy, done}, 0);

    // reset on shift bit 10 of a 32-bit load
    words[0] = 32'hDEAD_BEEF;
    load(32, 1, 0, -1, 10);
    check("abort_no_done", done_after_abort, 0);
    words[0] = 32'hA500_0000;
    load(8, 1, 0, -1, 0);
    check("restart_nbits", nbits, 8);
    check("restart_done_cyc", done_cyc, 9);

    // 36 bits with the 4-bit chain delay; captures are 4 zeros then word 0
    reset = 1'b1; tick(); reset = 1'b0; tick();
    words[0] = 32'h1234_5678; words[1] = 32'hABCD_EF01;
    load(36, 2, 0, -1, 0);
    check("t36_nbits", nbits, 36);
    check("t36_done_cyc", done_cyc, 38);
`ifdef CFG_READBACK_EN
    check("rb_count", rb_q.size(), 2);
    if (rb_q.size() == 2) begin
      check("rb_word0", rb_q[0], 32'h0123_4567);
      check("rb_word1", rb_q[1], 32'h8000_0000);
    end
`else
    check("rb_count", rb_q.size(), 0);
    check("rb_data_zero", rb_data, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/config_chain_loader.md
CONFIG_CHAIN_LOADER -- requirements
Module: config_chain_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning bitstream word width.
REQ-002 SHALL have parameter LEN_W, default 20, meaning chain-length counter width.
REQ-003 SHALL have port prog_clk  in  1  the only clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  single-cycle load request.
REQ-006 SHALL have port chain_len  in  LEN_W  total bits to shift; latched on an accepted start.
REQ-007 SHALL have port word_data  in  WORD_W  bitstream word, MSB shifted first.
REQ-008 SHALL have port word_valid  in  1  word_data valid.
REQ-009 SHALL have port word_ready  out  1  loader accepts a word.
REQ-010 SHALL have port sc_head  out  1  serial data into the chain head.
REQ-011 SHALL have port shift_en  out  1  prog_clk enable for the chain; one chain bit per high cycle.
REQ-012 SHALL have port config_enable  out  1  chain configuration window.
REQ-013 SHALL have port sc_tail  in  1  serial data from the chain tail.
REQ-014 SHALL have ports busy (out, 1) and done (out, 1): busy is high outside IDLE; done is a one-cycle completion pulse.
REQ-015 SHALL have ports rb_data (out, WORD_W) and rb_valid (out, 1): readback word and its one-cycle strobe.

Function
REQ-016 SHALL implement the FSM states IDLE, FETCH, SHIFT and DONE.
REQ-017 IDLE: on start with chain_len!=0, SHALL latch chain_len into remaining and go to FETCH; start with chain_len==0 SHALL go directly to DONE.
REQ-018 start outside IDLE SHALL be ignored.
REQ-019 FETCH: word_ready=1; on word_valid&word_ready SHALL load the shift register and set word_cnt=min(WORD_W, remaining), then go to SHIFT.
REQ-020 SHIFT: each cycle shift_en=1 and sc_head=shreg[WORD_W-1]; shreg shifts left, zero-filled; word_cnt and remaining each decrement by 1.
REQ-021 In SHIFT, when remaining reaches 0 the FSM SHALL go to DONE; otherwise, when word_cnt reaches 0 it SHALL go to FETCH.
REQ-022 Latency: the first bit of an accepted word SHALL appear on sc_head with shift_en=1 in the next cycle, giving one bubble cycle per word.
REQ-023 The unused LSBs of the last word (chain_len mod WORD_W != 0) SHALL be discarded and never driven out.
REQ-024 config_enable SHALL be 1 in FETCH and SHIFT and 0 otherwise.
REQ-025 sc_head and shift_en SHALL be 0 outside SHIFT.
REQ-026 DONE: done=1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-027 A stalled word_valid in FETCH SHALL hold all state, with shift_en=0.

Reset
REQ-028 On reset the FSM SHALL enter IDLE.
REQ-029 On reset word_ready, sc_head, shift_en, config_enable, busy, done, rb_valid and rb_data SHALL all be 0.
REQ-030 Reset mid-load SHALL abort without a done pulse; the partial chain content is left as-is.

Configuration
REQ-031 Macro CFG_READBACK_EN defined: on every shift_en cycle, sc_tail SHALL be captured into a WORD_W packer, first captured bit ending in bit WORD_W-1.
REQ-032 With CFG_READBACK_EN, after WORD_W captures, or at SHIFT->DONE with a partial word (zero-padded LSBs), rb_data SHALL update and rb_valid SHALL pulse for one cycle.
REQ-033 Macro CFG_READBACK_EN undefined: rb_data and rb_valid SHALL be constant 0 and no capture logic exists; the ports remain.

Structure
REQ-034 Package cfg_loader_pkg SHALL hold WORD_W/LEN_W defaults and the state enum (IDLE, FETCH, SHIFT, DONE).
REQ-035 Readback SHALL be sub-module cfg_readback_packer, instantiated only under CFG_READBACK_EN.

Verification
REQ-036 SHALL cover: chain_len=8, word 0xA5000000 -> sc_head 1,0,1,0,0,1,0,1 over 8 shift_en cycles, config_enable high throughout, done one cycle after the last bit.
REQ-037 SHALL cover: chain_len=40, words 0xFFFFFFFF then 0x80000000 -> 32 ones, 1 bubble, then 1 followed by seven 0s; 40 shift_en cycles total.
REQ-038 SHALL cover: chain_len=0 start -> done one cycle after start, with config_enable and shift_en never high.
REQ-039 SHALL cover: word_valid withheld 5 cycles in FETCH -> shift_en low and state held; the load resumes correctly; a second start while busy is ignored.
REQ-040 SHALL cover: reset asserted on shift bit 10 of chain_len=32 -> all outputs 0 next cycle, no done pulse, and a new start works.
REQ-041 SHALL cover: CFG_READBACK_EN with sc_tail looped to sc_head via a 4-bit delay, chain_len=36 -> rb_valid twice, the second rb_data holding its 4 valid bits in bits 31:28.
